// File: rtl/capture_sequencer_pkg.sv
// Shared definitions for the capture sequencer: FSM encoding, output word
// layout and the default test-pattern period.
package capture_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_DRAIN,
    ST_OVERFLOW
  } seqState_t;

  localparam int SAMPLE_WIDTH        = 10;
  localparam int WORD_WIDTH          = 16;
  localparam int FRAME_MARKER_BIT    = 15;
  localparam int DEFAULT_TEST_PERIOD = 1021;

  // Builds the FIFO word {frameStart, zero padding, sample}.
  function automatic logic [WORD_WIDTH-1:0] packWord(
    input logic                    frameStart,
    input logic [SAMPLE_WIDTH-1:0] sample
  );
    logic [WORD_WIDTH-1:0] word;
    word                         = '0;
    word[FRAME_MARKER_BIT]       = frameStart;
    word[SAMPLE_WIDTH-1:0]       = sample;
    return word;
  endfunction

endpackage

// File: rtl/capture_sequencer_test_sequence_checker.sv
// Test-pattern sequence checker: remembers the previous captured sample,
// compares each new one against previous+1 (wrapping at TEST_PERIOD-1) and
// keeps a saturating mismatch count.
module test_sequence_checker
  import capture_sequencer_pkg::*;
#(
  parameter int TEST_PERIOD = DEFAULT_TEST_PERIOD,
  parameter int ERR_WIDTH   = 16
) (
  input  logic                    clock,
  input  logic                    nReset,
  input  logic                    clear,
  input  logic                    enable,
  input  logic [SAMPLE_WIDTH-1:0] sample,
  output logic [ERR_WIDTH-1:0]    errorCount
);

  localparam logic [SAMPLE_WIDTH-1:0] LAST_VALUE = SAMPLE_WIDTH'(TEST_PERIOD - 1);

  logic [SAMPLE_WIDTH-1:0] previous;
  logic                    previousValid;
  logic [SAMPLE_WIDTH-1:0] expected;

  assign expected = (previous == LAST_VALUE) ? '0 : previous + SAMPLE_WIDTH'(1);

  // Track the previous sample and count mismatches; the first sample of a session only seeds the history.
  always_ff @(posedge clock or negedge nReset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!nReset) begin
      // NOTE: previous is reset even though previousValid gates its use, keeping simulation free of X.
      previous      <= '0;
      previousValid <= 1'b0;
      errorCount    <= '0;
    end else if (clear) begin
      previousValid <= 1'b0;
      errorCount    <= '0;
    end else if (enable) begin
      if (previousValid && (sample != expected) && (errorCount != '1)) begin
        errorCount <= errorCount + ERR_WIDTH'(1);
      end
      previous      <= sample;
      previousValid <= 1'b1;
    end
  end

endmodule

// File: rtl/capture_sequencer.sv
// Capture session controller: selects generator test mode, aligns to the test
// pattern, frames samples into 16-bit FIFO words and ends sessions on whole
// frames. fifoFull is evaluated at the edge that would launch a write, so a
// blocked write never reaches the fifoWrite register.
module capture_sequencer
  import capture_sequencer_pkg::*;
#(
  parameter int FRAME_SAMPLES = 32768,
  parameter int TEST_PERIOD   = DEFAULT_TEST_PERIOD,
  parameter int ERR_WIDTH     = 16
) (
  input  logic                    clock,
  input  logic                    nReset,
  input  logic                    captureRequest,
  input  logic                    testModeRequest,
  input  logic [SAMPLE_WIDTH-1:0] dataIn,
  input  logic                    fifoFull,
  output logic                    testModeFlag,
  output logic                    fifoWrite,
  output logic [WORD_WIDTH-1:0]   fifoData,
  output logic                    running,
  output logic                    overflow,
  output logic [ERR_WIDTH-1:0]    sequenceErrors
);

  localparam int                     INDEX_WIDTH = $clog2(FRAME_SAMPLES);
  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX  = INDEX_WIDTH'(FRAME_SAMPLES - 1);

  seqState_t              state;
  logic [INDEX_WIDTH-1:0] frameIndex;
  logic                   captureSlot;
  logic                   launchWrite;
  logic                   checkEnable;
  logic                   checkClear;

  // Decide whether this cycle's sample is captured and whether its write may be launched.
  always_comb begin
    // NOTE: every signal is defaulted first so no path through the case can infer a latch.
    captureSlot = 1'b0;
    case (state)
      ST_ARM:           captureSlot = captureRequest && testModeFlag && (dataIn == '0);
      ST_RUN, ST_DRAIN: captureSlot = 1'b1;
      default:          captureSlot = 1'b0;
    endcase
    launchWrite = captureSlot && !fifoFull;
    checkEnable = launchWrite && testModeFlag;
    checkClear  = (state == ST_IDLE) && captureRequest;
  end

  // Session FSM with registered outputs; the write path and the state transitions share one edge.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state        <= ST_IDLE;
      frameIndex   <= '0;
      testModeFlag <= 1'b0;
      fifoWrite    <= 1'b0;
      fifoData     <= '0;
      running      <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      fifoWrite <= 1'b0;
      if (launchWrite) begin
        fifoWrite  <= 1'b1;
        fifoData   <= packWord(frameIndex == '0, dataIn);
        frameIndex <= frameIndex + INDEX_WIDTH'(1);
      end

      case (state)
        ST_IDLE: begin
          testModeFlag <= testModeRequest;
          if (captureRequest) begin
            state      <= ST_ARM;
            running    <= 1'b1;
            overflow   <= 1'b0;
            frameIndex <= '0;
          end
        end

        ST_ARM: begin
          if (!captureRequest) begin
            state   <= ST_IDLE;
            running <= 1'b0;
          end else if (captureSlot && fifoFull) begin
            state    <= ST_OVERFLOW;
            running  <= 1'b0;
            overflow <= 1'b1;
          end else if (!testModeFlag || captureSlot) begin
            state <= ST_RUN;
          end
        end

        ST_RUN, ST_DRAIN: begin
          if (fifoFull) begin
            state    <= ST_OVERFLOW;
            running  <= 1'b0;
            overflow <= 1'b1;
          end else if ((frameIndex == LAST_INDEX) && ((state == ST_DRAIN) || !captureRequest)) begin
            state   <= ST_IDLE;
            running <= 1'b0;
          end else if (!captureRequest) begin
            state <= ST_DRAIN;
          end
        end

        ST_OVERFLOW: begin
          if (!captureRequest) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state   <= ST_IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

  test_sequence_checker #(
    .TEST_PERIOD (TEST_PERIOD),
    .ERR_WIDTH   (ERR_WIDTH)
  ) sequenceChecker (
    .clock      (clock),
    .nReset     (nReset),
    .clear      (checkClear),
    .enable     (checkEnable),
    .sample     (dataIn),
    .errorCount (sequenceErrors)
  );

endmodule

// File: tb/tb_capture_sequencer.sv
// Self-checking bench for capture_sequencer: a constant vector table for the
// ADC-mode framing case, directed sequences for test-mode alignment, pattern
// errors, overflow, mode latching and reset, then a randomized phase checked
// against a session-level reference model.
module tb_capture_sequencer;

  localparam int FRAME_SAMPLES = 4;
  localparam int TEST_PERIOD   = 1021;
  localparam int ERR_WIDTH     = 4;
  localparam int ERR_MAX       = (1 << ERR_WIDTH) - 1;

  logic                 clock = 1'b0;
  logic                 nReset;
  logic                 captureRequest;
  logic                 testModeRequest;
  logic [9:0]           dataIn;
  logic                 fifoFull;
  logic                 testModeFlag;
  logic                 fifoWrite;
  logic [15:0]          fifoData;
  logic                 running;
  logic                 overflow;
  logic [ERR_WIDTH-1:0] sequenceErrors;

  capture_sequencer #(
    .FRAME_SAMPLES (FRAME_SAMPLES),
    .TEST_PERIOD   (TEST_PERIOD),
    .ERR_WIDTH     (ERR_WIDTH)
  ) dut (
    .clock           (clock),
    .nReset          (nReset),
    .captureRequest  (captureRequest),
    .testModeRequest (testModeRequest),
    .dataIn          (dataIn),
    .fifoFull        (fifoFull),
    .testModeFlag    (testModeFlag),
    .fifoWrite       (fifoWrite),
    .fifoData        (fifoData),
    .running         (running),
    .overflow        (overflow),
    .sequenceErrors  (sequenceErrors)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;
  int writeCount = 0;

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual == required) passes++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, actual, required);
  endtask

  // Reference model: a session is described by counts of written samples,
  // frame position = writes modulo FRAME_SAMPLES, pattern check by modulo arithmetic.
  bit          mInSession, mWaiting, mStopping, mBlocked, mHavePrev;
  int          mWrites, mPrev;
  bit          eWrite, eRunning, eOverflow, eFlag;
  logic [15:0] eData;
  int          eErrors;

  task automatic modelReset();
    mInSession = 0; mWaiting = 0; mStopping = 0; mBlocked = 0; mHavePrev = 0;
    mWrites = 0; mPrev = 0;
    eWrite = 0; eRunning = 0; eOverflow = 0; eFlag = 0; eData = '0; eErrors = 0;
  endtask

  task automatic modelStep(input bit cr, input bit tm, input int d, input bit full);
    eWrite = 0;
    if (mBlocked) begin
      if (!cr) mBlocked = 0;
    end else if (!mInSession) begin
      eFlag = tm;
      if (cr) begin
        mInSession = 1; mWaiting = 1; mStopping = 0; eOverflow = 0;
        eErrors = 0; mWrites = 0; mHavePrev = 0;
      end
    end else if (mWaiting && !cr) begin
      mInSession = 0;
    end else if (mWaiting && !eFlag) begin
      mWaiting = 0;
    end else if (!mWaiting || d == 0) begin
      if (full) begin
        mBlocked = 1; mInSession = 0; eOverflow = 1;
      end else begin
        eWrite = 1;
        eData  = {(mWrites % FRAME_SAMPLES == 0), 5'b0, 10'(d)};
        if (eFlag) begin
          if (mHavePrev && d != (mPrev + 1) % TEST_PERIOD && eErrors < ERR_MAX) eErrors++;
          mPrev = d; mHavePrev = 1;
        end
        mWrites++;
        mWaiting = 0;
        if (!cr) mStopping = 1;
        if (mStopping && mWrites % FRAME_SAMPLES == 0) mInSession = 0;
      end
    end
    eRunning = mInSession;
  endtask

  task automatic compareModel();
    check("model_fifoWrite", int'(fifoWrite), int'(eWrite));
    if (eWrite) check("model_fifoData", int'(fifoData), int'(eData));
    check("model_running", int'(running), int'(eRunning));
    check("model_overflow", int'(overflow), int'(eOverflow));
    check("model_sequenceErrors", int'(sequenceErrors), eErrors);
    check("model_testModeFlag", int'(testModeFlag), int'(eFlag));
  endtask

  task automatic tick(input bit cr, input bit tm, input int d, input bit full);
    captureRequest  = cr;
    testModeRequest = tm;
    dataIn          = 10'(d);
    fifoFull        = full;
    @(posedge clock);
    modelStep(cr, tm, d, full);
    #1;
    writeCount += int'(fifoWrite);
    compareModel();
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_fifoWrite"}, int'(fifoWrite), 0);
    check({tag, "_fifoData"}, int'(fifoData), 0);
    check({tag, "_running"}, int'(running), 0);
    check({tag, "_overflow"}, int'(overflow), 0);
    check({tag, "_sequenceErrors"}, int'(sequenceErrors), 0);
    check({tag, "_testModeFlag"}, int'(testModeFlag), 0);
  endtask

  typedef struct {
    bit          cr;
    int          d;
    bit          full;
    bit          write;
    logic [15:0] data;
    bit          run;
  } vec_t;

  vec_t vecs[11];
  int   gen, startWrites, writesBefore, d;
  bit   crLevel, tmLevel, fullNow;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    nReset = 1'b0; captureRequest = 1'b0; testModeRequest = 1'b0; dataIn = '0; fifoFull = 1'b0;
    modelReset();
    #1;
    checkAllZero("reset");
    repeat (2) @(posedge clock);
    #3 nReset = 1'b1;

    // ADC mode, 4-sample frames: six samples under request, then drain to the boundary.
    vecs[0]  = '{1'b1,  0, 1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[1]  = '{1'b1, 10, 1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[2]  = '{1'b1, 11, 1'b0, 1'b1, 16'h800B, 1'b1};
    vecs[3]  = '{1'b1, 12, 1'b0, 1'b1, 16'h000C, 1'b1};
    vecs[4]  = '{1'b1, 13, 1'b0, 1'b1, 16'h000D, 1'b1};
    vecs[5]  = '{1'b1, 14, 1'b0, 1'b1, 16'h000E, 1'b1};
    vecs[6]  = '{1'b1, 15, 1'b0, 1'b1, 16'h800F, 1'b1};
    vecs[7]  = '{1'b1, 16, 1'b0, 1'b1, 16'h0010, 1'b1};
    vecs[8]  = '{1'b0, 17, 1'b0, 1'b1, 16'h0011, 1'b1};
    vecs[9]  = '{1'b0, 18, 1'b0, 1'b1, 16'h0012, 1'b0};
    vecs[10] = '{1'b0, 19, 1'b0, 1'b0, 16'h0000, 1'b0};
    startWrites = writeCount;
    for (int i = 0; i < 11; i++) begin
      tick(vecs[i].cr, 1'b0, vecs[i].d, vecs[i].full);
      check($sformatf("vec%0d_fifoWrite", i), int'(fifoWrite), int'(vecs[i].write));
      if (vecs[i].write) check($sformatf("vec%0d_fifoData", i), int'(fifoData), int'(vecs[i].data));
      check($sformatf("vec%0d_running", i), int'(running), int'(vecs[i].run));
    end
    check("adc_total_writes", writeCount - startWrites, 8);

    // Test mode entered with the generator at 500: wait for 0, then run across the wrap.
    tick(0, 1, 0, 0);
    check("tm_flag_latched", int'(testModeFlag), 1);
    gen = 500;
    startWrites = writeCount;
    tick(1, 1, gen, 0);
    gen = gen + 1;
    while (gen != 0) begin
      tick(1, 1, gen, 0);
      gen = (gen + 1) % TEST_PERIOD;
    end
    check("tm_no_writes_before_zero", writeCount - startWrites, 0);
    startWrites = writeCount;
    tick(1, 1, 0, 0);
    check("tm_first_write", int'(fifoWrite), 1);
    check("tm_first_word", int'(fifoData), 16'h8000);
    for (int k = 1; k <= 1023; k++) begin
      gen = k % TEST_PERIOD;
      tick(1, 1, gen, 0);
      if (k == 1) check("tm_word_1", int'(fifoData), 16'h0001);
      if (k == 2) check("tm_word_2", int'(fifoData), 16'h0002);
      if (k == 3) check("tm_word_3", int'(fifoData), 16'h0003);
      if (k == 4) check("tm_word_4_frame", int'(fifoData), 16'h8004);
    end
    check("tm_wrap_no_errors", int'(sequenceErrors), 0);

    // testModeRequest toggled during the session must not reach testModeFlag.
    for (int k = 0; k < 3; k++) begin
      gen = (gen + 1) % TEST_PERIOD;
      tick(1, 0, gen, 0);
    end
    check("tm_flag_held_in_run", int'(testModeFlag), 1);
    for (int k = 0; k < 8 && running; k++) begin
      gen = (gen + 1) % TEST_PERIOD;
      tick(0, 0, gen, 0);
    end
    check("tm_drain_reaches_idle", int'(running), 0);
    check("tm_whole_frames", (writeCount - startWrites) % FRAME_SAMPLES, 0);
    check("tm_flag_held_at_end", int'(testModeFlag), 1);
    tick(0, 0, 0, 0);
    check("tm_flag_follows_in_idle", int'(testModeFlag), 0);

    // One corrupted sample (7 instead of 6) costs two errors; capture continues.
    tick(0, 1, 0, 0);
    for (int v = 1018; v <= 1020; v++) tick(1, 1, v, 0);
    tick(1, 1, 0, 0);
    for (int s = 1; s <= 10; s++) tick(1, 1, (s == 6) ? 7 : s, 0);
    check("corrupt_errors", int'(sequenceErrors), 2);
    check("corrupt_still_running", int'(running), 1);

    // FIFO full in RUN: write suppressed, sticky overflow until the next ARM.
    tick(1, 1, 11, 1);
    check("ovf_no_write", int'(fifoWrite), 0);
    check("ovf_flag", int'(overflow), 1);
    check("ovf_not_running", int'(running), 0);
    tick(1, 1, 12, 0);
    tick(1, 1, 13, 0);
    check("ovf_hold_no_write", int'(fifoWrite), 0);
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    check("ovf_sticky_in_idle", int'(overflow), 1);
    tick(1, 1, 5, 0);
    check("ovf_cleared_on_arm", int'(overflow), 0);
    check("arm_running", int'(running), 1);
    check("arm_errors_cleared", int'(sequenceErrors), 0);

    // Error counter saturates at all-ones.
    tick(1, 1, 0, 0);
    for (int k = 0; k < 30; k++) tick(1, 1, 5, 0);
    check("errors_saturated", int'(sequenceErrors), ERR_MAX);
    tick(1, 1, 5, 0);
    check("errors_stay_saturated", int'(sequenceErrors), ERR_MAX);

    // Reset asserted between edges while draining.
    tick(0, 1, 5, 0);
    check("drain_running", int'(running), 1);
    tick(0, 1, 5, 0);
    check("drain_writing", int'(fifoWrite), 1);
    #2 nReset = 1'b0;
    #1;
    checkAllZero("midreset");
    modelReset();
    #3 nReset = 1'b1;
    tick(0, 0, 0, 0);
    check("post_reset_idle", int'(running), 0);
    tick(1, 0, 0, 0);
    check("post_reset_arm", int'(running), 1);
    tick(0, 0, 0, 0);
    check("post_reset_abort_arm", int'(running), 0);

    // Randomized sessions against the reference model.
    crLevel = 0; tmLevel = 0; gen = 0;
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 299) == 0) crLevel = !crLevel;
      if ($urandom_range(0, 9) == 0) tmLevel = !tmLevel;
      fullNow = ($urandom_range(0, 199) == 0);
      d = ($urandom_range(0, 49) == 0) ? int'($urandom_range(0, 1023)) : gen;
      tick(crLevel, tmLevel, d, fullNow);
      gen = (gen + 1) % TEST_PERIOD;
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
- Controls a capture session for the 10-bit sample stream produced by the data generator.
- Drives the generator's test-mode select and gates samples into the downstream USB FIFO as framed 16-bit words.
- Handles start/stop, test-pattern alignment, FIFO overflow, and verification of the test pattern sequence.
- Sits between the data generator and the FIFO/FX3 interface; control inputs are already synchronous to clock.

Parameters:
- FRAME_SAMPLES, 32768: samples per frame; must be a power of two and at least 4.
- TEST_PERIOD, 1021: test pattern period; the pattern runs 0..TEST_PERIOD-1, then wraps to 0.
- ERR_WIDTH, 16: width of the sequence error counter.

Ports:
- clock  in  1  sample clock; all logic is posedge.
- nReset  in  1  asynchronous, active-low reset.
- captureRequest  in  1  level; 1 = capture wanted.
- testModeRequest  in  1  level; test-mode selection for the next session.
- dataIn  in  10  sample from the data generator.
- fifoFull  in  1  downstream FIFO cannot accept a write this cycle.
- testModeFlag  out  1  test-mode select to the data generator.
- fifoWrite  out  1  write strobe.
- fifoData  out  16  {frameStart, 5'b0, sample[9:0]}.
- running  out  1  high in ARM, RUN and DRAIN.
- overflow  out  1  sticky overflow indication.
- sequenceErrors  out  ERR_WIDTH  count of test-pattern mismatches.

Behaviour:
- Reset values: every output is 0; the FSM is in IDLE; frame index = 0.
- FSM states: IDLE, ARM, RUN, DRAIN, OVERFLOW. All transitions occur on the clock edge.
- IDLE:
  - testModeFlag <= testModeRequest every cycle. This is the only state in which testModeFlag may change.
  - captureRequest=1 -> ARM. On this transition, clear sequenceErrors and overflow.
- ARM:
  - captureRequest=0 -> IDLE.
  - testModeFlag=0 -> RUN next cycle.
  - testModeFlag=1 -> stay until dataIn==0, then RUN. That dataIn==0 sample is the first sample written.
- RUN:
  - Each cycle, sample dataIn into the output register.
  - fifoWrite=1 one cycle later, with the registered sample on fifoData. Latency from dataIn to fifoData is exactly 1 cycle.
  - frameStart (fifoData[15]) = 1 when frame index==0. Frame index increments per write and wraps at FRAME_SAMPLES-1 -> 0.
  - fifoFull=1 in any cycle where a write would be issued -> suppress the write, set overflow=1, go to OVERFLOW. No partial frame continues.
  - captureRequest=0 -> DRAIN. Writes continue.
- DRAIN:
  - Keep writing until the write with frame index FRAME_SAMPLES-1 has been issued, then go to IDLE. The host therefore receives only whole frames.
  - If captureRequest falls exactly on a frame's last sample, go directly to IDLE after that write.
  - fifoFull in DRAIN is handled as in RUN.
  - captureRequest re-asserted during DRAIN is ignored; the session ends at the frame boundary, and a new session requires a fresh ARM.
- OVERFLOW:
  - fifoWrite=0; overflow held at 1.
  - captureRequest=0 -> IDLE. overflow remains 1 until the next ARM entry.
- Sequence check (test mode, RUN and DRAIN only):
  - expected = (previous sample == TEST_PERIOD-1) ? 0 : previous+1.
  - A mismatch increments sequenceErrors, saturating at all-ones.
  - The first sample after ARM is not checked.
- Widths: frame index is log2(FRAME_SAMPLES) bits. sequenceErrors is compared against its all-ones value, not incremented blindly.
- Reset mid-session: immediate return to IDLE; fifoWrite drops asynchronously.

Decomposition:
- Shared package holds:
  - FSM state encoding (ST_IDLE..ST_OVERFLOW).
  - FRAME_MARKER_BIT = 15.
  - TEST_PERIOD default.
- One natural sub-module, test_sequence_checker: holds previous sample, compares, and owns the saturating error counter. It is enabled by the FSM and cleared on ARM entry.

Test Plan:
- ADC mode, FRAME_SAMPLES=4: raise captureRequest, then drop it after 6 samples -> exactly 8 writes; frameStart on writes 1 and 5; returns to IDLE; running=0.
- Test mode, generator at 500 when ARM is entered -> no writes until dataIn==0; first fifoData=16'h8000; then 1, 2, 3...; sequenceErrors=0 across the 1020->0 wrap.
- Test mode, inject one corrupted sample (7 instead of 6) -> sequenceErrors=2 (corrupted sample plus the following one); capture continues.
- Assert fifoFull in RUN -> no write that cycle; overflow=1; state OVERFLOW; drop captureRequest -> IDLE with overflow still 1; next ARM clears it.
- Toggle testModeRequest during RUN -> testModeFlag is unchanged until the session returns to IDLE.
- Assert nReset low during DRAIN -> all outputs 0 immediately; FSM IDLE after release.
